lock_unit: RTL

Shared lock responder for the multi-core build. Sits between the cores' ID stages and the lock table. Each core raises a lock or unlock request for a lock ID and holds it until this block pulses that core's acknowledge. The core's hazard logic stalls on an outstanding request without `lock_ac`. This block arbitrates among cores round-robin, owns the per-lock held/owner state, and decides each cycle which request completes.

---
 rtl/lock_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/lock_unit.sv
// lock_unit: shared lock responder for the multi-core build.
//
// Each core holds a lock or unlock request (level) until this block pulses its
// acknowledge. One request is evaluated per cycle. A round-robin pointer picks
// the winner, and the pointer moves past the winner whether it is granted or
// denied. The block keeps a held bit and an owner for every lock.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high
//   lock_en    [NCORE]      per-core lock request (level)
//   unlock_en  [NCORE]      per-core unlock request (level)
//   lock_id    [NCORE*LW]   per-core lock id, core c at [c*LW +: LW]
//   lock_ac    [NCORE]      registered one-cycle acknowledge
//   lock_held  [NLOCK]      debug view of held bits
//   lock_err   1            sticky protocol-error flag

// Per-core front end: slices the core's id and masks the request that is
// still visible during its own ack cycle (it is the one just acknowledged).
module lock_unit_lane #(
    parameter int LW = 3
) (
    input  logic          lock_en,
    input  logic          unlock_en,
    input  logic          ac,
    input  logic [LW-1:0] id_in,
    output logic          elig,
    output logic [LW-1:0] id
);
    assign elig = (lock_en | unlock_en) & ~ac;
    assign id   = id_in;
endmodule

module lock_unit #(
    parameter int NCORE = 2,
    parameter int NLOCK = 8,
    parameter int LW    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NCORE-1:0]    lock_en,
    input  logic [NCORE-1:0]    unlock_en,
    input  logic [NCORE*LW-1:0] lock_id,
    output logic [NCORE-1:0]    lock_ac,
    output logic [NLOCK-1:0]    lock_held,
    output logic                lock_err
);
    localparam int CW = (NCORE > 2) ? 2 : 1;

    typedef struct packed {
        logic          vld;
        logic [CW-1:0] core;
        logic          lock;
        logic          unlock;
        logic [LW-1:0] id;
    } req_t;

    logic [NLOCK-1:0]          held;
    logic [NLOCK-1:0][CW-1:0]  owner;
    logic [CW-1:0]             rr;
    logic                      err;

    logic [NCORE-1:0]          elig;
    logic [NCORE-1:0][LW-1:0]  ids;
    req_t                      win;
    int                        idx;

    logic [NCORE-1:0]          ac_nxt;
    logic                      set_err;
    logic                      grant_set;
    logic                      grant_clr;
    logic                      tgt_held;
    logic                      tgt_own;
    logic [CW-1:0]             rr_nxt;

    for (genvar c = 0; c < NCORE; c++) begin : g_lane
        lock_unit_lane #(.LW(LW)) u_lane (
            .lock_en   (lock_en[c]),
            .unlock_en (unlock_en[c]),
            .ac        (lock_ac[c]),
            .id_in     (lock_id[c*LW +: LW]),
            .elig      (elig[c]),
            .id        (ids[c])
        );
    end

    // First eligible core at or after rr, wrapping upward.
    always_comb begin
        win = '0;
        idx = 0;
        for (int k = 0; k < NCORE; k++) begin
            idx = int'(rr) + k;
            if (idx >= NCORE) idx = idx - NCORE;
            if (!win.vld && elig[idx]) begin
                win.vld    = 1'b1;
                win.core   = CW'(idx);
                win.lock   = lock_en[idx];
                win.unlock = unlock_en[idx];
                win.id     = ids[idx];
            end
        end
    end

    // Evaluate the winner against the lock table. Both lock and unlock high
    // is handled as an unlock and flagged. Bad unlocks and re-entrant locks
    // are still acked so the core never deadlocks. Only a lock held by
    // another core is denied.
    always_comb begin
        ac_nxt    = '0;
        set_err   = 1'b0;
        grant_set = 1'b0;
        grant_clr = 1'b0;
        tgt_held  = held[win.id];
        tgt_own   = (owner[win.id] == win.core);
        rr_nxt    = (win.core == CW'(NCORE - 1)) ? '0 : win.core + 1'b1;
        if (win.vld) begin
            if (win.unlock) begin
                ac_nxt[win.core] = 1'b1;
                if (win.lock) set_err = 1'b1;
                if (tgt_held && tgt_own) grant_clr = 1'b1;
                else                     set_err   = 1'b1;
            end else if (!tgt_held) begin
                grant_set        = 1'b1;
                ac_nxt[win.core] = 1'b1;
            end else if (tgt_own) begin
                ac_nxt[win.core] = 1'b1;
                set_err          = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held    <= '0;
            owner   <= '0;
            rr      <= '0;
            err     <= 1'b0;
            lock_ac <= '0;
        end else begin
            lock_ac <= ac_nxt;
            if (win.vld) rr <= rr_nxt;
            if (set_err) err <= 1'b1;
            if (grant_set) begin
                held[win.id]  <= 1'b1;
                owner[win.id] <= win.core;
            end
            if (grant_clr) held[win.id] <= 1'b0;
        end
    end

    assign lock_held = held;
    assign lock_err  = err;

endmodule
